// File: rtl/calc_pkg.sv
// Shared types and segment constants for the calculator display path.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2,
        ERROR = 2'd3
    } disp_state_t;

    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_E    = 7'h79;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to 7-segment pattern (segments a..g on bits 0..6, active high).
module hex_to_seg7 (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure lookup from nibble to segment pattern
    always_comb begin
        seg = 7'h00;
        case (hex)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/calc_result_display.sv
// Accepts a calculator result over valid/ready and drives one 7-segment digit,
// blanking briefly on every accept and blinking 'E' for flagged results.
module calc_result_display
    import calc_pkg::*;
#(
    parameter int BLANK_CYCLES = 4,
    parameter int BLINK_DIV    = 22
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] result,
    input  logic       result_flag,
    input  logic       result_valid,
    output logic       result_ready,
    input  logic       display_en,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int CW = BLINK_DIV + 1;
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES - 1);

    disp_state_t   state_r;
    logic [BW-1:0] blank_cnt_r;
    logic [CW-1:0] blink_cnt_r;
    logic [3:0]    value_r;
    logic          flag_r;
    logic [6:0]    hex_seg_s;
    logic [6:0]    seg_next_s;
    logic          dp_next_s;
    logic          accept_s;

    hex_to_seg7 u_hex_to_seg7 (
        .hex (value_r),
        .seg (hex_seg_s)
    );

    assign result_ready = (state_r != BLANK);
    assign accept_s     = result_valid && result_ready;

    // Output pattern for the current state; registered below so it lags state by one cycle
    always_comb begin
        seg_next_s = SEG_OFF;
        dp_next_s  = 1'b0;
        if (display_en) begin
            case (state_r)
                IDLE:    seg_next_s = SEG_DASH;
                BLANK:   seg_next_s = SEG_OFF;
                SHOW:    seg_next_s = hex_seg_s;
                ERROR: begin
                    seg_next_s = blink_cnt_r[BLINK_DIV] ? SEG_OFF : SEG_E;
                    dp_next_s  = 1'b1;
                end
                default: seg_next_s = SEG_OFF;
            endcase
        end else begin
            seg_next_s = SEG_OFF;
            dp_next_s  = 1'b0;
        end
    end

    // Display FSM, blank/blink counters, latched result and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            blank_cnt_r <= '0;
            blink_cnt_r <= '0;
            value_r     <= 4'h0;
            flag_r      <= 1'b0;
            seg         <= SEG_DASH;
            dp          <= 1'b0;
        end else begin
            seg <= seg_next_s;
            dp  <= dp_next_s;
            // An accept from any ready state restarts the blank, discarding blink phase
            if (accept_s) begin
                state_r     <= BLANK;
                blank_cnt_r <= BLANK_LOAD;
                value_r     <= result;
                flag_r      <= result_flag;
            end else begin
                case (state_r)
                    IDLE: state_r <= IDLE;
                    BLANK: begin
                        if (blank_cnt_r == '0) begin
                            state_r     <= flag_r ? ERROR : SHOW;
                            blink_cnt_r <= '0;
                        end else begin
                            blank_cnt_r <= blank_cnt_r - BW'(1);
                        end
                    end
                    SHOW:  state_r <= SHOW;
                    ERROR: blink_cnt_r <= blink_cnt_r + CW'(1);
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/calc_result_display.md
Name: calc_result_display

Overview:
Consumer end of the calculator result path: accepts a 4-bit result over a valid/ready handshake and drives one 7-segment digit plus decimal point.
- Each accepted value is shown after a short blank gap, so repeated identical results are visibly re-updated.
- Flagged results (overflow/error) show a blinking 'E' with the decimal point lit.
- Sits between the calculator core output and uo_out.

Parameters:
BLANK_CYCLES, 4, cycles the digit is blanked after each accepted result (min 1)
BLINK_DIV, 22, error blink half-period is 2**BLINK_DIV cycles

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
result  input  4  hex value to display
result_flag  input  1  result is invalid/overflowed; show error instead of value
result_valid  input  1  result/result_flag are valid this cycle
result_ready  output  1  block accepts a result this cycle
display_en  input  1  0 forces segments and dp dark; state unaffected
seg  output  7  segments a..g on bits 0..6, active high, registered
dp  output  1  decimal point, active high, registered

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset), sampled on rising clk.
- Reset: state IDLE, seg=7'h40 (dash), dp=0, counters=0, latched value=0, latched flag=0; result_ready=1 in the first cycle after reset.
- States: IDLE, BLANK, SHOW, ERROR.
- result_ready = 1 in IDLE/SHOW/ERROR, 0 in BLANK; driven combinationally from state.
- Accept: result_valid && result_ready on an edge latches result and flag, enters BLANK, loads blank counter with BLANK_CYCLES-1.
- BLANK: seg=0, dp=0. Counter decrements each cycle. On the edge where counter==0, go to SHOW if latched flag==0, else ERROR. Blank lasts exactly BLANK_CYCLES cycles.
- SHOW: seg=hex decode of latched value, dp=0, held indefinitely.
- ERROR:
  - Blink counter clears on entry; visible phase first.
  - seg alternates E code (7'h79) / 0 every 2**BLINK_DIV cycles.
  - dp=1 for the whole state.
- Hex codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Output timing: seg/dp are registered, so they reflect the state/value one cycle after the transition edge.
- IDLE: seg=7'h40, dp=0.
- display_en=0: seg=0, dp=0 on the next edge. Handshake, counters and state continue. Restoring display_en resumes the correct pattern on the next edge.
- New accept while in SHOW or ERROR: immediately re-enters BLANK and restarts the blank count. Blink phase is discarded.
- result_valid during BLANK is ignored (ready=0); no skid buffer. The upstream producer holds valid until ready.
- reset in any state, including mid-BLANK: returns to IDLE on that edge and discards the latched value; outputs as above.
- Blink counter width is BLINK_DIV+1 bits and wraps freely in ERROR.

Decomposition:
- calc_pkg:
  - state enum disp_state_t {IDLE, BLANK, SHOW, ERROR}
  - constants SEG_DASH=7'h40, SEG_E=7'h79, SEG_OFF=7'h00
- One combinational sub-module hex_to_seg7 (4-bit in, 7-bit out), reused by later display blocks.
- The FSM, counters and output registers stay in calc_result_display.

Test Plan:
- Bench overrides: BLANK_CYCLES=3, BLINK_DIV=2 throughout.
- reset=1 for 2 cycles, then release → seg=40, dp=0, result_ready=1, no change while result_valid=0.
- result=4'h8, flag=0, valid for 1 cycle → ready=0 for 3 cycles, seg=00 during blank, then seg=7F, dp=0, ready=1.
- result=4'hA, flag=1 → after blank, dp=1; seg=79 for 4 cycles, 00 for 4, 79 for 4 (repeats).
- Valid held high continuously with 3 then 5 → 3 accepted, ready low 3 cycles, then 5 accepted the first ready cycle; seg shows 4F briefly? No: 4F for exactly 1 cycle before re-blank, then 6D.
- In SHOW with seg=06, drop display_en → seg=00, dp=00 next edge. Accept 2 while disabled; re-enable after 10 cycles → seg=5B.
- Assert reset during 2nd BLANK cycle → next edge seg=40, ready=1. A subsequent accept of F shows 71 after 3 blank cycles.
